pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter D, default 12, giving the program-counter width in bits.
REQ-002 SHALL have parameter SD, default 4, giving the return-stack depth, used only when PC_RETURN_STACK_EN is defined.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  level; launches program execution from address 0.
REQ-006 halt_req  input  1  current instruction is the halt/done instruction.
REQ-007 stall  input  1  hold prog_ctr this cycle.
REQ-008 abs_jump_en  input  1  absolute jump instruction decoded.
REQ-009 rel_jump_en  input  1  relative jump instruction decoded.
REQ-010 branch_cond  input  1  condition for abs/rel jumps; jump taken only when 1.
REQ-011 target  input  D  absolute target from the jump lookup table.
REQ-012 rel_offset  input  8  signed two's-complement relative offset.
REQ-013 call_en  input  1  call instruction decoded; uses target.
REQ-014 ret_en  input  1  return instruction decoded.
REQ-015 prog_ctr  output  D  current instruction address.
REQ-016 running  output  1  high in state RUN.
REQ-017 done  output  1  high in state DONE.
REQ-018 stack_err  output  1  sticky return-stack overflow/underflow flag.

Function
REQ-019 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-020 IDLE: prog_ctr held at 0; start=1 -> RUN with prog_ctr=0 on the next cycle.
REQ-021 RUN: when stall=1, prog_ctr and stack are held and all control inputs are ignored, including halt_req.
REQ-022 RUN, stall=0, next prog_ctr priority: halt_req (hold, go DONE) > ret_en > call_en > abs_jump_en&branch_cond (target) > rel_jump_en&branch_cond (prog_ctr + sign-extended rel_offset) > prog_ctr+1.
REQ-023 Abs/rel jump with branch_cond=0 SHALL advance to prog_ctr+1.
REQ-024 All address arithmetic is modulo 2^D; 2^D-1 + 1 wraps to 0; 0 + (-1) wraps to 2^D-1.
REQ-025 DONE: prog_ctr holds the halt address, done=1; start=1 -> RUN with prog_ctr=0 next cycle.
REQ-026 start is ignored in RUN.
REQ-027 Latency: every prog_ctr update is visible one cycle after the controlling inputs are sampled; no combinational path from inputs to prog_ctr.
REQ-028 running and done are registered decodes of state, never both high.

Reset
REQ-029 reset=1 SHALL force IDLE, prog_ctr=0, running=0, done=0, stack_err=0, stack pointer=0 on the next edge, overriding all inputs, including mid-program and mid-stall.

Configuration
REQ-030 Macro PC_RETURN_STACK_EN defined: SD-entry LIFO of D-bit return addresses.
REQ-031 With the macro, call_en pushes prog_ctr+1 and loads target; ret_en pops into prog_ctr.
REQ-032 With the macro, a call when the stack is full sets stack_err, discards the push, and still jumps.
REQ-033 With the macro, a ret when the stack is empty sets stack_err and advances to prog_ctr+1.
REQ-034 Without the macro: call_en behaves as an unconditional absolute jump, ret_en behaves as prog_ctr+1, stack_err is tied 0, and no stack storage exists.
REQ-035 start from DONE clears the stack pointer; stack_err clears only on reset.

Structure
REQ-036 Shared package pc_pkg SHALL hold the state enum (IDLE/RUN/DONE), the default D, SD, and the rel_offset width constant.
REQ-037 The return stack SHALL be the sub-module ret_stack (push, pop, data in/out, full, empty), instantiated only under PC_RETURN_STACK_EN.

Verification
REQ-038 Reset, then start=1 one cycle, 5 idle instruction cycles -> prog_ctr 0,1,2,3,4,5 with running=1.
REQ-039 At prog_ctr=3: abs_jump_en=1, branch_cond=1, target=17 -> prog_ctr=17; repeat with branch_cond=0 -> prog_ctr=4.
REQ-040 At prog_ctr=30: rel_jump_en=1, branch_cond=1, rel_offset=-6 -> 24; at prog_ctr=4095, plain advance -> 0.
REQ-041 Macro on, at prog_ctr=10: call target=54 -> 54; later ret -> 11; five nested calls (SD=4) -> stack_err=1 and the fifth jump is still taken.
REQ-042 At prog_ctr=91: halt_req=1 with stall=1 -> no change; stall=0 -> done=1, prog_ctr=91 held; start -> prog_ctr=0, running=1.
REQ-043 reset asserted mid-RUN at prog_ctr=76 -> next cycle prog_ctr=0, IDLE, stack_err=0.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared state type and default widths for the program-counter sequencer.
// Optional return stack is enabled by defining PC_RETURN_STACK_EN.
package pc_pkg;
   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   localparam int PC_D  = 12;
   localparam int PC_SD = 4;
   localparam int REL_W = 8;
endpackage

// File: rtl/ret_stack.sv
// ret_stack: small LIFO of return addresses; push/pop are ignored when full/empty.
// Only instantiated when PC_RETURN_STACK_EN is defined.
module ret_stack
   import pc_pkg::*;
#(
   parameter int D  = PC_D,
   parameter int SD = PC_SD
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [D-1:0] data_i,
   output logic [D-1:0] data_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int PW = $clog2(SD + 1);

   logic [D-1:0]  mem_q [SD];
   logic [PW-1:0] sp_q, sp_d;

   assign full_o  = (sp_q == PW'(SD));
   assign empty_o = (sp_q == '0);

   always_comb begin
      data_o = '0;
      for (int i = 0; i < SD; i++) begin
         if (PW'(i + 1) == sp_q) data_o = mem_q[i];
      end
   end

   always_comb begin
      sp_d = sp_q;
      if (clear_i) sp_d = '0;
      else if (push_i && !full_o) sp_d = sp_q + PW'(1);
      else if (pop_i && !empty_o) sp_d = sp_q - PW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) sp_q <= '0;
      else sp_q <= sp_d;
   end

   // Entries need no reset: they are only read below the pointer.
   always_ff @(posedge clk) begin
      for (int i = 0; i < SD; i++) begin
         if (push_i && !full_o && PW'(i) == sp_q) mem_q[i] <= data_i;
      end
   end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: IDLE/RUN/DONE program counter with jumps, calls and returns.
// Define PC_RETURN_STACK_EN to add a hardware return stack with stack_err.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int D  = PC_D,
   parameter int SD = PC_SD
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             halt_req,
   input  logic             stall,
   input  logic             abs_jump_en,
   input  logic             rel_jump_en,
   input  logic             branch_cond,
   input  logic [D-1:0]     target,
   input  logic [REL_W-1:0] rel_offset,
   input  logic             call_en,
   input  logic             ret_en,
   output logic [D-1:0]     prog_ctr,
   output logic             running,
   output logic             done,
   output logic             stack_err
);
   state_e       state_q, state_d;
   logic [D-1:0] pc_q, pc_d;
   logic [D-1:0] pc_inc, pc_rel;
   logic         running_q, done_q;

`ifdef PC_RETURN_STACK_EN
   logic         err_q, err_d;
   logic         push, pop, clr;
   logic         stk_full, stk_empty;
   logic [D-1:0] stk_top;

   ret_stack #(
      .D (D),
      .SD(SD)
   ) u_ret_stack (
      .clk    (clk),
      .reset  (reset),
      .clear_i(clr),
      .push_i (push),
      .pop_i  (pop),
      .data_i (pc_inc),
      .data_o (stk_top),
      .full_o (stk_full),
      .empty_o(stk_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) err_q <= 1'b0;
      else err_q <= err_d;
   end

   assign stack_err = err_q;
`else
   assign stack_err = 1'b0;
`endif

   assign pc_inc = pc_q + D'(1);
   assign pc_rel = pc_q + {{(D-REL_W){rel_offset[REL_W-1]}}, rel_offset};

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
`ifdef PC_RETURN_STACK_EN
      err_d = err_q;
      push  = 1'b0;
      pop   = 1'b0;
      clr   = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               pc_d    = '0;
            end
         end
         RUN: begin
            // A stalled cycle freezes everything, halt included.
            if (!stall) begin
               if (halt_req) begin
                  state_d = DONE;
               end else if (ret_en) begin
`ifdef PC_RETURN_STACK_EN
                  if (stk_empty) begin
                     err_d = 1'b1;
                     pc_d  = pc_inc;
                  end else begin
                     pop  = 1'b1;
                     pc_d = stk_top;
                  end
`else
                  pc_d = pc_inc;
`endif
               end else if (call_en) begin
`ifdef PC_RETURN_STACK_EN
                  if (stk_full) err_d = 1'b1;
                  else push = 1'b1;
`endif
                  pc_d = target;
               end else if (abs_jump_en && branch_cond) begin
                  pc_d = target;
               end else if (rel_jump_en && branch_cond) begin
                  pc_d = pc_rel;
               end else begin
                  pc_d = pc_inc;
               end
            end
         end
         DONE: begin
            if (start) begin
               state_d = RUN;
               pc_d    = '0;
`ifdef PC_RETURN_STACK_EN
               clr = 1'b1;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         running_q <= (state_d == RUN);
         done_q    <= (state_d == DONE);
      end
   end

   assign prog_ctr = pc_q;
   assign running  = running_q;
   assign done     = done_q;
endmodule
